uart_sram_dump: RTL and testbench
=================================

UART_SRAM_DUMP -- requirements
Module: uart_sram_dump

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clock cycles per UART bit (115200 baud at 50 MHz).
REQ-002 SHALL have parameter SRAM_READ_LATENCY, default 2, meaning cycles from SRAM_address presented to SRAM_read_data valid.
REQ-003 SHALL have port Clock, input, 1, meaning single system clock; all state updates on its rising edge.
REQ-004 SHALL have port Resetn, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port Start, input, 1, meaning request to dump a region; sampled only in S_IDLE.
REQ-006 SHALL have port Start_address, input, 18, meaning first SRAM word address; latched when Start is accepted.
REQ-007 SHALL have port Word_count, input, 18, meaning number of 16-bit words to send; latched when Start is accepted.
REQ-008 SHALL have port SRAM_read_data, input, 16, meaning read data from the SRAM controller.
REQ-009 SHALL have port SRAM_address, output, 18, meaning word address to the SRAM controller.
REQ-010 SHALL have port SRAM_we_n, output, 1, meaning SRAM write enable; constant 1 because the block never writes.
REQ-011 SHALL have port UART_TX_O, output, 1, meaning serial line, idle high.
REQ-012 SHALL have port Busy, output, 1, meaning a dump is in progress.
REQ-013 SHALL have port Done, output, 1, meaning one-cycle pulse at dump completion.

Function
REQ-014 SHALL implement states S_IDLE, S_FETCH, S_WAIT, S_TX_HIGH, S_TX_LOW and S_FINISH.
REQ-015 SHALL leave S_IDLE only on Start=1, latching the address and count, setting Busy=1 and entering S_FETCH on the next edge.
REQ-016 SHALL, on Start with Word_count=0, send nothing and go to S_FINISH, so Done pulses 2 cycles after Start is sampled.
REQ-017 SHALL drive SRAM_address=Start_address in S_FETCH and capture SRAM_read_data exactly SRAM_READ_LATENCY cycles later (S_WAIT).
REQ-018 SHALL send each word as two 8N1 frames: high byte first, then low byte, each LSB first, with start bit 0 and stop bit 1.
REQ-019 SHALL hold every bit on UART_TX_O for exactly CLKS_PER_BIT cycles, so each word takes 20*CLKS_PER_BIT cycles.
REQ-020 SHALL prefetch the next word into a holding register while the current high byte is sent, so frames follow back-to-back with no idle cycles after the first.
REQ-021 SHALL increment the address modulo 2^18 after each word, wrapping 0x3FFFF to 0x00000.
REQ-022 SHALL, after the last word's low-byte stop bit completes, enter S_FINISH for one cycle with Done=1 and Busy=0, then return to S_IDLE.
REQ-023 SHALL ignore Start while Busy=1, leaving the latched address and count unchanged.
REQ-024 SHALL keep UART_TX_O=1 in S_IDLE and S_FINISH.

Reset
REQ-025 SHALL, while Resetn=0 at any time including mid-frame, force S_IDLE, UART_TX_O=1, Busy=0, Done=0, SRAM_address=0, SRAM_we_n=1, and clear all counters and data registers.
REQ-026 SHALL resume with no partial frame after reset release and accept Start on the first edge after release.

Verification (CLKS_PER_BIT=4, SRAM model latency 2)
REQ-027 SHALL verify single word: SRAM[0x100]=0xA55A, Start_address=0x100, Word_count=1 -> line decodes bytes 0xA5, 0x5A; 80 cycles of frame; Done one cycle; SRAM_we_n stays 1.
REQ-028 SHALL verify streaming: Word_count=3 at 0x200 holding 0x0102, 0x0304, 0x0506 -> bytes 01 02 03 04 05 06 with no idle bits between frames, 240 frame cycles.
REQ-029 SHALL verify wrap: Start_address=0x3FFFF, Word_count=2 -> reads addresses 0x3FFFF then 0x00000.
REQ-030 SHALL verify zero count: Word_count=0 -> no start bit, Done 2 cycles after Start, Busy never seen high on a sampled edge after that.
REQ-031 SHALL verify Start while busy: second Start during word 1 of 3 -> ignored, exactly 6 bytes sent, one Done.
REQ-032 SHALL verify reset mid-dump: Resetn low during bit 3 of frame 2 -> UART_TX_O=1 and Busy=0 immediately; a new Start after release produces a clean dump.

Source files
------------

// File: rtl/uart_sram_dump.sv
// uart_sram_dump: reads a block of 16-bit SRAM words and streams them out
// as 8N1 UART frames. Each word is sent high byte first. The next word is
// prefetched while the current high byte is on the line, so that frames
// follow each other with no idle time.
module uart_sram_dump #(
   parameter int unsigned CLKS_PER_BIT      = 434,
   parameter int unsigned SRAM_READ_LATENCY = 2
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        Start,
   input  logic [17:0] Start_address,
   input  logic [17:0] Word_count,
   input  logic [15:0] SRAM_read_data,
   output logic [17:0] SRAM_address,
   output logic        SRAM_we_n,
   output logic        UART_TX_O,
   output logic        Busy,
   output logic        Done
);

   localparam int unsigned ADDR_W = 18;
   localparam int unsigned CNT_W  = 18;
   localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned LAT_W  = (SRAM_READ_LATENCY > 0) ? $clog2(SRAM_READ_LATENCY + 1) : 1;
   localparam int unsigned BIT_W  = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_TX_HIGH,
      S_TX_LOW,
      S_FINISH
   } state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [CNT_W-1:0]    cnt_q;       // words still to send after the current one
   logic [7:0]          low_q;       // low byte of the word on the line
   logic [15:0]         hold_q;      // prefetched next word
   logic [8:0]          sh_q;        // remaining data bits plus stop bit
   logic [BIT_W-1:0]    bit_idx_q;   // 0 = start bit, 9 = stop bit
   logic [BAUD_W-1:0]   baud_q;
   logic [LAT_W-1:0]    lat_q;
   logic                pf_done_q;
   logic                tx_q;
   logic                busy_q;
   logic                done_q;

   logic                tx_active_c;
   logic                baud_end_c;
   logic                frame_end_c;

   // Bit timing decode shared by both byte states
   always_comb begin
      tx_active_c = (state_q == S_TX_HIGH) || (state_q == S_TX_LOW);
      baud_end_c  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
      frame_end_c = baud_end_c && (bit_idx_q == BIT_W'(9));
   end

   // Dump sequencer, SRAM fetch/prefetch and UART serializer
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         cnt_q     <= '0;
         low_q     <= '0;
         hold_q    <= '0;
         sh_q      <= '0;
         bit_idx_q <= '0;
         baud_q    <= '0;
         lat_q     <= '0;
         pf_done_q <= 1'b0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;

         if (tx_active_c) begin
            if (baud_end_c) begin
               baud_q <= '0;
               if (!frame_end_c) begin
                  tx_q      <= sh_q[0];
                  sh_q      <= {1'b1, sh_q[8:1]};
                  bit_idx_q <= bit_idx_q + BIT_W'(1);
               end
            end else begin
               baud_q <= baud_q + BAUD_W'(1);
            end
         end

         case (state_q)
            S_IDLE: begin
               tx_q <= 1'b1;
               if (Start) begin
                  addr_q  <= Start_address;
                  cnt_q   <= Word_count;
                  busy_q  <= 1'b1;
                  state_q <= S_FETCH;
               end
            end

            S_FETCH: begin
               if (cnt_q == '0) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_FINISH;
               end else begin
                  lat_q   <= LAT_W'(1);
                  state_q <= S_WAIT;
               end
            end

            S_WAIT: begin
               if (lat_q == LAT_W'(SRAM_READ_LATENCY)) begin
                  low_q     <= SRAM_read_data[7:0];
                  addr_q    <= addr_q + ADDR_W'(1);
                  cnt_q     <= cnt_q - CNT_W'(1);
                  pf_done_q <= (cnt_q == CNT_W'(1));
                  lat_q     <= '0;
                  tx_q      <= 1'b0;
                  sh_q      <= {1'b1, SRAM_read_data[15:8]};
                  bit_idx_q <= '0;
                  baud_q    <= '0;
                  state_q   <= S_TX_HIGH;
               end else begin
                  lat_q <= lat_q + LAT_W'(1);
               end
            end

            S_TX_HIGH: begin
               // Address is already the next word; capture it after the read latency
               if (!pf_done_q) begin
                  if (lat_q == LAT_W'(SRAM_READ_LATENCY)) begin
                     hold_q    <= SRAM_read_data;
                     addr_q    <= addr_q + ADDR_W'(1);
                     pf_done_q <= 1'b1;
                  end else begin
                     lat_q <= lat_q + LAT_W'(1);
                  end
               end
               if (frame_end_c) begin
                  tx_q      <= 1'b0;
                  sh_q      <= {1'b1, low_q};
                  bit_idx_q <= '0;
                  state_q   <= S_TX_LOW;
               end
            end

            S_TX_LOW: begin
               if (frame_end_c) begin
                  if (cnt_q != '0) begin
                     low_q     <= hold_q[7:0];
                     cnt_q     <= cnt_q - CNT_W'(1);
                     pf_done_q <= (cnt_q == CNT_W'(1));
                     lat_q     <= '0;
                     tx_q      <= 1'b0;
                     sh_q      <= {1'b1, hold_q[15:8]};
                     bit_idx_q <= '0;
                     state_q   <= S_TX_HIGH;
                  end else begin
                     tx_q    <= 1'b1;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_FINISH;
                  end
               end
            end

            S_FINISH: begin
               tx_q    <= 1'b1;
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign SRAM_address = addr_q;
   assign SRAM_we_n    = 1'b1;
   assign UART_TX_O    = tx_q;
   assign Busy         = busy_q;
   assign Done         = done_q;

endmodule

// File: tb/tb_uart_sram_dump.sv
// Directed bench for uart_sram_dump with CLKS_PER_BIT=4 and a 2-cycle SRAM model.
module tb_uart_sram_dump;

   localparam int unsigned CPB    = 4;
   localparam int unsigned LAT    = 2;
   localparam int          BUDGET = 1000;

   logic        clock_50;
   logic        Resetn;
   logic        Start;
   logic [17:0] Start_address;
   logic [17:0] Word_count;
   logic [15:0] SRAM_read_data;
   logic [17:0] SRAM_address;
   logic        SRAM_we_n;
   logic        UART_TX_O;
   logic        Busy;
   logic        Done;

   int checks = 0;
   int errors = 0;

   // Results of the most recent dump run
   logic        tx_log [$];
   logic [7:0]  bytes [$];
   int          gaps, glitches, first_start, done_idx, done_cycles;
   int          busy_after, we_bad, timed_out;
   logic        tx_rst, busy_rst, done_rst;
   logic [17:0] addr_rst, final_addr;

   logic [15:0] mem [logic [17:0]];
   logic [15:0] d1, d2;

   uart_sram_dump #(.CLKS_PER_BIT(CPB), .SRAM_READ_LATENCY(LAT)) dut (
      .Clock          (clock_50),
      .Resetn         (Resetn),
      .Start          (Start),
      .Start_address  (Start_address),
      .Word_count     (Word_count),
      .SRAM_read_data (SRAM_read_data),
      .SRAM_address   (SRAM_address),
      .SRAM_we_n      (SRAM_we_n),
      .UART_TX_O      (UART_TX_O),
      .Busy           (Busy),
      .Done           (Done)
   );

   initial clock_50 = 1'b0;
   always #10 clock_50 = ~clock_50;

   function automatic logic [15:0] rd(input logic [17:0] a);
      if (mem.exists(a)) return mem[a];
      return 16'h0000;
   endfunction

   // Two-stage SRAM read pipeline
   always @(posedge clock_50) begin
      d1 <= rd(SRAM_address);
      d2 <= d1;
   end
   assign SRAM_read_data = d2;

   // Decode 8N1 frames from the per-cycle line log (log[k] = value sampled at edge k)
   function automatic void decode();
      int p, q;
      logic v;
      logic [7:0] b;
      bytes.delete();
      gaps = 0; glitches = 0; first_start = -1;
      p = 1;
      while (p < tx_log.size() && tx_log[p] == 1'b1) p++;
      if (p >= tx_log.size()) return;
      first_start = p;
      while (1) begin
         if (p + 10 * CPB > tx_log.size()) begin glitches++; break; end
         b = '0;
         for (int i = 0; i < 10; i++) begin
            v = tx_log[p + CPB * i];
            for (int j = 1; j < CPB; j++)
               if (tx_log[p + CPB * i + j] !== v) glitches++;
            if (i >= 1 && i <= 8) b[i-1] = v;
            if (i == 0 && v !== 1'b0) glitches++;
            if (i == 9 && v !== 1'b1) glitches++;
         end
         bytes.push_back(b);
         q = p + 10 * CPB;
         while (q < tx_log.size() && tx_log[q] == 1'b1) q++;
         if (q >= tx_log.size()) break;
         gaps += q - (p + 10 * CPB);
         p = q;
      end
   endfunction

   // Start a dump and record the line each cycle until Done (or abort on reset)
   task automatic run_dump(input logic [17:0] a, input logic [17:0] n,
                           input int extra_at, input int rst_at, input bit release_rst);
      int k;
      tx_log.delete();
      tx_log.push_back(1'b1);
      done_idx = -1; done_cycles = 0; busy_after = 0; we_bad = 0; timed_out = 0;
      @(negedge clock_50);
      if (release_rst) Resetn = 1'b1;
      Start_address = a; Word_count = n; Start = 1'b1;
      k = 0;
      while (1) begin
         @(negedge clock_50);
         k++;
         Start = 1'b0; Start_address = a; Word_count = n;
         tx_log.push_back(UART_TX_O);
         if (SRAM_we_n !== 1'b1) we_bad++;
         if (Done === 1'b1) begin
            done_cycles++;
            if (done_idx < 0) done_idx = k;
         end
         if (done_idx >= 0 && k > done_idx && Busy === 1'b1) busy_after++;
         if (k == extra_at) begin
            Start = 1'b1; Start_address = 18'h00000; Word_count = 18'd1;
         end
         if (k == rst_at) begin
            Resetn = 1'b0;
            #1;
            tx_rst = UART_TX_O; busy_rst = Busy; done_rst = Done; addr_rst = SRAM_address;
            return;
         end
         if (done_idx >= 0 && k >= done_idx + 5) break;
         if (k >= BUDGET) begin timed_out = 1; break; end
      end
      final_addr = SRAM_address;
      decode();
   endtask

   task automatic test_reset();
      Resetn = 1'b0; Start = 1'b0; Start_address = '0; Word_count = '0;
      repeat (3) @(negedge clock_50);
      checks++; if (UART_TX_O !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", UART_TX_O); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", Done); end
      checks++; if (SRAM_address !== 18'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", SRAM_address); end
      checks++; if (SRAM_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n: got %b expected 1", SRAM_we_n); end
      Resetn = 1'b1;
      repeat (2) @(negedge clock_50);
      checks++; if (UART_TX_O !== 1'b1 || Busy !== 1'b0) begin
         errors++; $display("FAIL idle_after_reset: got tx=%b busy=%b expected tx=1 busy=0", UART_TX_O, Busy);
      end
   endtask

   task automatic test_single();
      mem[18'h100] = 16'hA55A;
      run_dump(18'h100, 18'd1, -1, -1, 1'b0);
      checks++; if (timed_out != 0) begin errors++; $display("FAIL single_timeout: got %0d expected 0", timed_out); end
      checks++; if (bytes.size() != 2) begin errors++; $display("FAIL single_nbytes: got %0d expected 2", bytes.size()); end
      else begin
         checks++; if (bytes[0] !== 8'hA5) begin errors++; $display("FAIL single_byte0: got %h expected a5", bytes[0]); end
         checks++; if (bytes[1] !== 8'h5A) begin errors++; $display("FAIL single_byte1: got %h expected 5a", bytes[1]); end
      end
      checks++; if (glitches != 0) begin errors++; $display("FAIL single_bit_timing: got %0d expected 0", glitches); end
      checks++; if (first_start != 4) begin errors++; $display("FAIL single_first_start: got %0d expected 4", first_start); end
      checks++; if (done_idx - first_start != 80) begin errors++; $display("FAIL single_frame_cycles: got %0d expected 80", done_idx - first_start); end
      checks++; if (done_cycles != 1) begin errors++; $display("FAIL single_done_width: got %0d expected 1", done_cycles); end
      checks++; if (we_bad != 0) begin errors++; $display("FAIL single_we_n: got %0d expected 0", we_bad); end
      checks++; if (busy_after != 0) begin errors++; $display("FAIL single_busy_after: got %0d expected 0", busy_after); end
      checks++; if (final_addr !== 18'h101) begin errors++; $display("FAIL single_final_addr: got %h expected 101", final_addr); end
   endtask

   task automatic test_stream();
      logic [7:0] exp_b [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      mem[18'h200] = 16'h0102; mem[18'h201] = 16'h0304; mem[18'h202] = 16'h0506;
      run_dump(18'h200, 18'd3, -1, -1, 1'b0);
      checks++; if (bytes.size() != 6) begin errors++; $display("FAIL stream_nbytes: got %0d expected 6", bytes.size()); end
      else for (int i = 0; i < 6; i++) begin
         checks++; if (bytes[i] !== exp_b[i]) begin errors++; $display("FAIL stream_byte%0d: got %h expected %h", i, bytes[i], exp_b[i]); end
      end
      checks++; if (gaps != 0) begin errors++; $display("FAIL stream_gaps: got %0d expected 0", gaps); end
      checks++; if (glitches != 0) begin errors++; $display("FAIL stream_bit_timing: got %0d expected 0", glitches); end
      checks++; if (done_idx - first_start != 240) begin errors++; $display("FAIL stream_frame_cycles: got %0d expected 240", done_idx - first_start); end
      checks++; if (final_addr !== 18'h203) begin errors++; $display("FAIL stream_final_addr: got %h expected 203", final_addr); end
   endtask

   task automatic test_wrap();
      logic [7:0] exp_b [4] = '{8'hBE, 8'hEF, 8'hC0, 8'h01};
      mem[18'h3FFFF] = 16'hBEEF; mem[18'h00000] = 16'hC001;
      run_dump(18'h3FFFF, 18'd2, -1, -1, 1'b0);
      checks++; if (bytes.size() != 4) begin errors++; $display("FAIL wrap_nbytes: got %0d expected 4", bytes.size()); end
      else for (int i = 0; i < 4; i++) begin
         checks++; if (bytes[i] !== exp_b[i]) begin errors++; $display("FAIL wrap_byte%0d: got %h expected %h", i, bytes[i], exp_b[i]); end
      end
      checks++; if (final_addr !== 18'h00001) begin errors++; $display("FAIL wrap_final_addr: got %h expected 00001", final_addr); end
   endtask

   task automatic test_zero_count();
      run_dump(18'h123, 18'd0, -1, -1, 1'b0);
      checks++; if (first_start != -1) begin errors++; $display("FAIL zero_start_bit: got %0d expected -1", first_start); end
      checks++; if (done_idx != 2) begin errors++; $display("FAIL zero_done_edge: got %0d expected 2", done_idx); end
      checks++; if (done_cycles != 1) begin errors++; $display("FAIL zero_done_width: got %0d expected 1", done_cycles); end
      checks++; if (busy_after != 0) begin errors++; $display("FAIL zero_busy_after: got %0d expected 0", busy_after); end
   endtask

   task automatic test_start_while_busy();
      logic [7:0] exp_b [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      run_dump(18'h200, 18'd3, 30, -1, 1'b0);
      checks++; if (bytes.size() != 6) begin errors++; $display("FAIL busy_start_nbytes: got %0d expected 6", bytes.size()); end
      else for (int i = 0; i < 6; i++) begin
         checks++; if (bytes[i] !== exp_b[i]) begin errors++; $display("FAIL busy_start_byte%0d: got %h expected %h", i, bytes[i], exp_b[i]); end
      end
      checks++; if (done_cycles != 1) begin errors++; $display("FAIL busy_start_done: got %0d expected 1", done_cycles); end
      checks++; if (done_idx - first_start != 240) begin errors++; $display("FAIL busy_start_cycles: got %0d expected 240", done_idx - first_start); end
   endtask

   task automatic test_reset_mid_dump();
      logic [7:0] exp_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      mem[18'h300] = 16'h1122; mem[18'h301] = 16'h3344; mem[18'h302] = 16'h5566;
      // Frame 2 starts at edge 44; bit 3 spans edges 56..59
      run_dump(18'h300, 18'd3, -1, 57, 1'b0);
      checks++; if (tx_rst !== 1'b1) begin errors++; $display("FAIL midrst_tx: got %b expected 1", tx_rst); end
      checks++; if (busy_rst !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy_rst); end
      checks++; if (done_rst !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done_rst); end
      checks++; if (addr_rst !== 18'h0) begin errors++; $display("FAIL midrst_addr: got %h expected 0", addr_rst); end
      repeat (2) @(negedge clock_50);
      run_dump(18'h300, 18'd2, -1, -1, 1'b1);
      checks++; if (bytes.size() != 4) begin errors++; $display("FAIL after_rst_nbytes: got %0d expected 4", bytes.size()); end
      else for (int i = 0; i < 4; i++) begin
         checks++; if (bytes[i] !== exp_b[i]) begin errors++; $display("FAIL after_rst_byte%0d: got %h expected %h", i, bytes[i], exp_b[i]); end
      end
      checks++; if (first_start != 4) begin errors++; $display("FAIL after_rst_first_start: got %0d expected 4", first_start); end
      checks++; if (glitches != 0 || gaps != 0) begin errors++; $display("FAIL after_rst_clean: got glitches=%0d gaps=%0d expected 0 0", glitches, gaps); end
      checks++; if (done_idx - first_start != 160) begin errors++; $display("FAIL after_rst_cycles: got %0d expected 160", done_idx - first_start); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_wrap();
      test_zero_count();
      test_start_while_busy();
      test_reset_mid_dump();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
